// File: rtl/nmr_pkg.sv
// nmr_pkg: shared lane/system state types and lane word field offsets for the NMR voter
package nmr_pkg;
  typedef enum logic [1:0] {ACTIVE, SUSPECT, ISOLATED, RESYNC} lane_state_t;
  typedef enum logic [1:0] {NOMINAL = 2'd0, DEGRADED = 2'd1, FAIL = 2'd2} sys_state_t;
  localparam int MEMWRITE_OFF = 0;
  localparam int RD2_OFF      = 1;
  localparam int ALURES_OFF   = 33;
  localparam int PC_OFF       = 65;
endpackage

// File: rtl/nmr_lane_monitor.sv
// nmr_lane_monitor: per-lane health FSM with fault/resync counter and isolation/readmission requests
module nmr_lane_monitor
  import nmr_pkg::*;
#(
  parameter int FAULT_THRESH = 4,
  parameter int RESYNC_LEN   = 8,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_mismatch,
  input  logic i_resync_req,
  input  logic i_isolate_permit,
  output logic o_active,
  output logic o_compare,
  output logic o_ack,
  output logic o_wants_isolate,
  output logic o_wants_readmit
);
  localparam logic [CNT_W:0] FT = (CNT_W+1)'(FAULT_THRESH);
  localparam logic [CNT_W:0] RL = (CNT_W+1)'(RESYNC_LEN);
  lane_state_t r_st;
  logic [CNT_W-1:0] r_cnt;
  logic r_ack;
  logic [CNT_W:0] w_inc;
  assign w_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign o_active = (r_st == ACTIVE) | (r_st == SUSPECT);
  assign o_compare = r_st != ISOLATED;
  assign o_ack = r_ack;
  // ACTIVE always holds cnt=0, so a threshold of 1 isolates straight from ACTIVE
  assign o_wants_isolate = i_valid & i_mismatch & o_active & (w_inc >= FT);
  assign o_wants_readmit = i_valid & ~i_mismatch & i_resync_req & (r_st == RESYNC) & (w_inc >= RL);
  // Lane state and counter; a blocked isolation leaves the lane SUSPECT with cnt pinned at the threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= ACTIVE;
      r_cnt <= '0;
      r_ack <= 1'b0;
    end else begin
      r_ack <= o_wants_readmit;
      case (r_st)
        ACTIVE, SUSPECT:
          if (i_valid) begin
            if (o_wants_isolate && i_isolate_permit) begin
              r_st  <= ISOLATED;
              r_cnt <= '0;
            end else if (i_mismatch) begin
              r_st  <= SUSPECT;
              r_cnt <= (w_inc >= FT) ? FT[CNT_W-1:0] : w_inc[CNT_W-1:0];
            end else begin
              r_st  <= ACTIVE;
              r_cnt <= '0;
            end
          end
        ISOLATED:
          if (i_resync_req) begin
            r_st  <= RESYNC;
            r_cnt <= '0;
          end
        default:
          if (!i_resync_req) begin
            r_st  <= ISOLATED;
            r_cnt <= '0;
          end else if (o_wants_readmit) begin
            r_st  <= ACTIVE;
            r_cnt <= '0;
          end else if (i_valid) begin
            r_cnt <= i_mismatch ? '0 : w_inc[CNT_W-1:0];
          end
      endcase
    end
  end
endmodule

// File: rtl/nmr_voter_ctrl.sv
// nmr_voter_ctrl: registered N-modular-redundancy bitwise voter with lane isolation/readmission; NMR_ERR_LOG_EN adds err_count/last_syndrome
module nmr_voter_ctrl
  import nmr_pkg::*;
#(
  parameter int NUM_LANES    = 3,
  parameter int DATA_W       = 97,
  parameter int FAULT_THRESH = 4,
  parameter int RESYNC_LEN   = 8,
  parameter int CNT_W        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_data,
  input  logic [NUM_LANES-1:0]          resync_req,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [NUM_LANES-1:0]          lane_mismatch,
  output logic [NUM_LANES-1:0]          lane_active,
  output logic [NUM_LANES-1:0]          resync_ack,
  output logic [1:0]                    sys_state,
  output logic                          uncorrectable
`ifdef NMR_ERR_LOG_EN
  ,
  output logic [NUM_LANES*16-1:0]       err_count,
  output logic [DATA_W-1:0]             last_syndrome
`endif
);
  logic [NUM_LANES-1:0] w_active, w_cmp, w_wants, w_readmit, w_permit, w_mm, w_ack;
  logic [DATA_W-1:0] w_voted;
  logic w_unc, w_a_two, w_full;
  logic r_out_valid, r_unc;
  logic [DATA_W-1:0] r_out_data;
  logic [NUM_LANES-1:0] r_mm;
  sys_state_t r_sys;

  // Per-bit majority over active lanes; any tied bit makes the whole word uncorrectable
  always_comb begin
    int na, ones;
    w_voted = '0;
    w_unc   = 1'b0;
    na      = 0;
    for (int i = 0; i < NUM_LANES; i++) na += int'(w_active[i]);
    for (int b = 0; b < DATA_W; b++) begin
      ones = 0;
      for (int i = 0; i < NUM_LANES; i++) ones += int'(w_active[i] & lane_data[i*DATA_W+b]);
      w_voted[b] = 2 * ones > na;
      w_unc      = w_unc | (2 * ones == na);
    end
    w_a_two = na == 2;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_mm[g] = in_valid & ~w_unc & w_cmp[g] & (lane_data[g*DATA_W +: DATA_W] != w_voted);
    nmr_lane_monitor #(
      .FAULT_THRESH(FAULT_THRESH),
      .RESYNC_LEN  (RESYNC_LEN),
      .CNT_W       (CNT_W)
    ) u_mon (
      .clk             (clk),
      .rst             (rst),
      .i_valid         (in_valid),
      .i_mismatch      (w_mm[g]),
      .i_resync_req    (resync_req[g]),
      .i_isolate_permit(w_permit[g]),
      .o_active        (w_active[g]),
      .o_compare       (w_cmp[g]),
      .o_ack           (w_ack[g]),
      .o_wants_isolate (w_wants[g]),
      .o_wants_readmit (w_readmit[g])
    );
  end

  // Grant isolations in ascending lane order while at least two voters remain, counting same-cycle readmissions
  always_comb begin
    int avail;
    w_permit = '0;
    avail    = 0;
    for (int i = 0; i < NUM_LANES; i++) avail += int'(w_active[i]) + int'(w_readmit[i]);
    for (int i = 0; i < NUM_LANES; i++)
      if (w_wants[i] && avail > 2) begin
        w_permit[i] = 1'b1;
        avail--;
      end
    w_full = avail == NUM_LANES;
  end

  // Voted output and per-valid-cycle status; an uncorrectable word keeps the previous data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_mm        <= '0;
      r_unc       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_mm  <= w_mm;
        r_unc <= w_unc;
        if (!w_unc) r_out_data <= w_voted;
      end
    end
  end

  // System health from next-cycle voter count; a two-lane tie latches FAIL until reset
  always_ff @(posedge clk) begin
    if (rst) r_sys <= NOMINAL;
    else r_sys <= (r_sys == FAIL || (in_valid && w_unc && w_a_two)) ? FAIL : w_full ? NOMINAL : DEGRADED;
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign lane_mismatch = r_mm;
  assign lane_active   = w_active;
  assign resync_ack    = w_ack;
  assign sys_state     = r_sys;
  assign uncorrectable = r_unc;

`ifdef NMR_ERR_LOG_EN
  logic [NUM_LANES*16-1:0] r_err;
  logic [DATA_W-1:0] r_syn, w_syn;
  // Syndrome of the lowest-index mismatching lane
  always_comb begin
    w_syn = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (w_mm[i]) w_syn = lane_data[i*DATA_W +: DATA_W] ^ w_voted;
  end
  // Saturating per-lane mismatch counters and last captured syndrome
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
      r_syn <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (w_mm[i] && r_err[i*16 +: 16] != 16'hFFFF) r_err[i*16 +: 16] <= r_err[i*16 +: 16] + 16'd1;
      if (|w_mm) r_syn <= w_syn;
    end
  end
  assign err_count     = r_err;
  assign last_syndrome = r_syn;
`endif
endmodule

// File: doc/nmr_voter_ctrl.md
Name: nmr_voter_ctrl

Overview:
- Parametrised N-modular-redundancy voter and lane-health controller; successor to the fixed three-core combinational voter between the redundant Main_core instances and memory.
- Performs registered bitwise majority over NUM_LANES packed core outputs (PC, ALUResult, RD2, MemWrite).
- Tracks per-lane disagreement and isolates persistently faulty lanes.
- Readmits isolated lanes through a resync handshake.

Parameters:
- NUM_LANES, 3, number of redundant lanes; odd, 3..7.
- DATA_W, 97, packed width per lane ({PC[31:0], ALUResult[31:0], RD2[31:0], MemWrite}).
- FAULT_THRESH, 4, consecutive mismatching valid cycles before a lane is isolated; 1..(2^CNT_W-1).
- RESYNC_LEN, 8, consecutive agreeing valid cycles needed to readmit a lane.
- CNT_W, 4, width of the per-lane counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  lane_data is valid this cycle.
- lane_data  in  NUM_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- resync_req  in  NUM_LANES  per-lane request to readmit an isolated lane (level, held until ack).
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  voted word.
- lane_mismatch  out  NUM_LANES  registered per-lane disagreement flag for the last valid cycle.
- lane_active  out  NUM_LANES  lane currently participates in voting.
- resync_ack  out  NUM_LANES  one-cycle pulse on readmission.
- sys_state  out  2  0=NOMINAL, 1=DEGRADED, 2=FAIL.
- uncorrectable  out  1  no majority existed for the last valid cycle.

Behaviour:
- Reset (clk edge with rst=1):
  - out_valid=0, out_data=0, lane_mismatch=0, lane_active=all 1, resync_ack=0, sys_state=NOMINAL, uncorrectable=0.
  - All counters 0; all lane FSMs ACTIVE.
  - rst overrides in-flight resyncs.
- Latency: one cycle. in_valid at edge N gives out_valid and out_data at edge N+1. in_valid=0 gives out_valid=0 with out_data held.
- Vote: per bit, count ones among active lanes (A = popcount of lane_active).
  - Result bit = 1 if 2*ones > A, and 0 if 2*ones < A.
  - A tie (only possible with even A) marks the word uncorrectable.
  - When uncorrectable, out_data holds its previous value, out_valid=1, uncorrectable=1.
- Mismatch: lane_mismatch[i] = (lane_i != voted) for active lanes, and for RESYNC lanes (compared against voted). Forced 0 for ISOLATED lanes, and 0 on uncorrectable cycles.
- Lane FSM (per lane, valid cycles only):
  - ACTIVE: a mismatch sets cnt=1 and moves to SUSPECT.
  - SUSPECT: agreement clears cnt and returns to ACTIVE. Mismatch does cnt++; when cnt reaches FAULT_THRESH, go to ISOLATED and clear lane_active (the next cycle's vote excludes the lane).
  - ISOLATED: resync_req[i] goes to RESYNC with cnt=0. The lane is still excluded from the vote.
  - RESYNC: agreement does cnt++, mismatch clears cnt. When cnt reaches RESYNC_LEN, go to ACTIVE, set lane_active, pulse resync_ack[i]. Dropping resync_req aborts back to ISOLATED.
  - FAULT_THRESH=1 isolates on the first mismatch (ACTIVE goes directly to ISOLATED).
- Isolation guard: a lane is never isolated if that would leave A<2. It stays SUSPECT with cnt saturated.
- sys_state (registered from next-state lane_active):
  - NOMINAL if A==NUM_LANES.
  - DEGRADED if 2<=A<NUM_LANES.
  - FAIL if uncorrectable was asserted on an A==2 cycle. FAIL is sticky until rst.
- Simultaneous events:
  - Multiple lanes may cross the threshold in one cycle. Isolate in ascending index order while the guard permits.
  - Readmission and isolation in the same cycle: A is updated with both.
- Counters saturate and never wrap.

Optional Feature:
- NMR_ERR_LOG_EN defined:
  - Adds output err_count (NUM_LANES*16): per-lane saturating count of valid mismatch cycles; reset to 0, never cleared otherwise.
  - Adds output last_syndrome (DATA_W): lane XOR voted for the lowest-index mismatching lane, captured on each mismatch cycle.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package nmr_pkg:
  - lane_state_t enum (ACTIVE, SUSPECT, ISOLATED, RESYNC).
  - sys_state_t enum (NOMINAL, DEGRADED, FAIL).
  - Packing offsets for the PC, ALUResult, RD2 and MemWrite fields.
- Sub-module nmr_lane_monitor:
  - Per-lane FSM plus counter, generated NUM_LANES times.
  - Inputs: mismatch, valid, resync_req, isolate_permit.
  - Outputs: active, ack, wants_isolate.

Test Plan:
- NUM_LANES=3, all lanes 0x1234 for 5 valid cycles -> out_data=0x1234 one cycle later each time; lane_mismatch=0; sys_state=NOMINAL.
- Lane1=0xFFFF and others 0x1234 for 1 cycle -> out_data=0x1234, lane_mismatch=3'b010; lane1 SUSPECT; agreement on the next cycle returns it to ACTIVE with no isolation.
- Lane2 wrong for 4 consecutive cycles -> lane_active=3'b011 after the 4th; sys_state=DEGRADED; later lane2 errors are ignored.
- With lane2 isolated, lanes 0/1 differ -> uncorrectable=1, out_data holds the previous value, sys_state=FAIL (sticky); rst restores NOMINAL with all lanes active.
- With lane2 isolated, assert resync_req[2] and present 8 agreeing cycles -> resync_ack[2] pulses once, lane_active=3'b111, NOMINAL. A mismatch at cycle 5 restarts the count.
- rst asserted mid-RESYNC with in_valid=1 -> all outputs at reset values the next cycle; out_valid=0.
